mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single `mem_controller` port between the instruction skin path (`iosc_ins` side, "ins") and the core's other-data path ("oth").
- Sits between the requesters and `mem_controller`; sequences exactly one memory transaction at a time.
- Latches each granted request, issues it to memory, times the read return, and returns data plus an ack pulse to the winner.

Parameters:
- DATA_WIDTH, 32, width of address and data buses.
- RD_LAT, 1, cycles from the memory read-enable cycle to the cycle `i_mem_rdata` is valid. Legal values are 1 to 15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_ins_ren  in  1  ins read request (level, held until ack)
- i_ins_wen  in  1  ins write request (level, held until ack)
- i_ins_addr  in  DATA_WIDTH  ins address
- i_ins_wdata  in  DATA_WIDTH  ins write data
- o_ins_rdata  out  DATA_WIDTH  ins read data; valid in the ack cycle, held until the next ins read ack
- o_ins_ack  out  1  one-cycle completion pulse to ins
- i_oth_ren, i_oth_wen, i_oth_addr, i_oth_wdata, o_oth_rdata, o_oth_ack: same as the ins ports, for the oth requester
- o_mem_ren  out  1  read enable to mem_controller
- o_mem_wen  out  1  write enable to mem_controller
- o_mem_addr  out  DATA_WIDTH  memory address
- o_mem_wdata  out  DATA_WIDTH  memory write data
- i_mem_rdata  in  DATA_WIDTH  memory read data
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; FSM = IDLE; round-robin pointer = ins (ins has next priority).
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples the requests. A port is requesting when its ren or wen is high.
  - With no request, stays in IDLE.
  - Otherwise picks the winner and latches its op, addr and wdata. Next state is ISSUE.
  - If a port raises both ren and wen, it is treated as a write.
- ISSUE (exactly 1 cycle):
  - Drives the latched addr/wdata and exactly one of o_mem_ren or o_mem_wen.
  - After a write, next state is DONE. After a read, next state is WAIT.
- WAIT: lasts exactly RD_LAT cycles, counted by a down-counter. On its last cycle, `i_mem_rdata` is captured into the winner's rdata register. Next state is DONE.
- DONE (1 cycle):
  - The winner's ack is high. The other ack is 0. Both mem enables are 0.
  - Requests are not sampled in DONE. Next state is IDLE.
- Latency, with the request first seen in IDLE at cycle T:
  - write: mem_wen at T+1, ack at T+2
  - read: mem_ren at T+1, ack at T+2+RD_LAT
- Throughput: at most one transaction every 3 cycles (writes) or 3+RD_LAT cycles (reads).
- Requester rule: a requester must deassert, or present its next request, by the cycle after its ack. Request lines are ignored outside IDLE.
- rdata of the non-winning port is never modified.
- Arbitration: if only one port requests, it wins. If both request, the port selected by the RR pointer wins. The pointer then moves to the other port.
- Reset asserted mid-transaction: the transaction is aborted with no ack. On the next edge all outputs return to their reset values.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin as described above.
- Undefined: fixed priority, ins always wins when both request. The pointer register is not built. oth may starve; this is accepted.

Decomposition:
- Package mem_arb_pkg holds:
  - the FSM state encoding (IDLE, ISSUE, WAIT, DONE)
  - port IDs PORT_INS = 0, PORT_OTH = 1
  - op encoding OP_RD, OP_WR
- One sub-module, mem_arb_pick:
  - combinational winner select from the two request bits plus the pointer;
  - contains the MEM_ARB_RR_EN logic and the pointer update.
- The FSM, latch registers and WAIT counter stay in mem_arbiter.

Test Plan:
- ins write only, addr 0x10, wdata 0xA5A5A5A5, RD_LAT=1 -> o_mem_wen=1 with addr 0x10 and data 0xA5A5A5A5 at T+1; o_ins_ack at T+2; o_oth_ack stays 0.
- oth read, addr 0x20, memory returns 0x12345678, RD_LAT=3 -> o_mem_ren at T+1; o_oth_rdata=0x12345678 and o_oth_ack at T+5; o_ins_rdata unchanged.
- Both ports hold read requests continuously (MEM_ARB_RR_EN defined) -> grant order ins, oth, ins, oth; acks alternate; no port is acked twice in a row.
- Same stimulus with MEM_ARB_RR_EN undefined -> every grant goes to ins; o_oth_ack never pulses while ins keeps requesting.
- ins raises ren and wen together -> only o_mem_wen is pulsed; ack follows write timing (T+2).
- rst asserted during WAIT of an ins read -> no o_ins_ack; next cycle all outputs are 0; after rst is released, a pending oth request is served with normal latency.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the two-requester memory arbiter.
//   state_e    : FSM encoding (IDLE, ISSUE, WAIT, DONE)
//   port_id_e  : requester identity (PORT_INS = 0, PORT_OTH = 1)
//   op_e       : latched operation (OP_RD, OP_WR)
//   CNT_W      : width of the read-latency down-counter (RD_LAT is 1..15)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    PORT_INS = 1'b0,
    PORT_OTH = 1'b1
  } port_id_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports and the memory-controller
// port of mem_arbiter.
//   ins side : i_ins_ren, i_ins_wen, i_ins_addr, i_ins_wdata -> o_ins_rdata, o_ins_ack
//   oth side : i_oth_ren, i_oth_wen, i_oth_addr, i_oth_wdata -> o_oth_rdata, o_oth_ack
//   memory   : o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata <- i_mem_rdata
//   status   : o_busy
// Modport slave is the arbiter's view; modport master is the environment's
// view (requesters plus memory model).
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  i_ins_ren;
  logic                  i_ins_wen;
  logic [DATA_WIDTH-1:0] i_ins_addr;
  logic [DATA_WIDTH-1:0] i_ins_wdata;
  logic [DATA_WIDTH-1:0] o_ins_rdata;
  logic                  o_ins_ack;

  logic                  i_oth_ren;
  logic                  i_oth_wen;
  logic [DATA_WIDTH-1:0] i_oth_addr;
  logic [DATA_WIDTH-1:0] i_oth_wdata;
  logic [DATA_WIDTH-1:0] o_oth_rdata;
  logic                  o_oth_ack;

  logic                  o_mem_ren;
  logic                  o_mem_wen;
  logic [DATA_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  logic                  o_busy;

  modport slave (
    input  i_ins_ren, i_ins_wen, i_ins_addr, i_ins_wdata,
    output o_ins_rdata, o_ins_ack,
    input  i_oth_ren, i_oth_wen, i_oth_addr, i_oth_wdata,
    output o_oth_rdata, o_oth_ack,
    output o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata,
    output o_busy
  );

  modport master (
    output i_ins_ren, i_ins_wen, i_ins_addr, i_ins_wdata,
    input  o_ins_rdata, o_ins_ack,
    output i_oth_ren, i_oth_wen, i_oth_addr, i_oth_wdata,
    input  o_oth_rdata, o_oth_ack,
    input  o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata,
    output i_mem_rdata,
    input  o_busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select for mem_arbiter.
// Ports:
//   reqIns_i, reqOth_i : port is requesting (ren | wen)
//   ptr_i              : round-robin pointer, port with next priority   (MEM_ARB_RR_EN only)
//   ptrNext_o          : pointer value to load when a grant is taken     (MEM_ARB_RR_EN only)
//   valid_o            : at least one port is requesting
//   winner_o           : granted port
// Macro MEM_ARB_RR_EN: defined selects round-robin on contention; undefined
// selects fixed priority with ins always winning (no pointer exists).
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  port_id_e ptr_i,
  output port_id_e ptrNext_o,
`endif
  input  logic     reqIns_i,
  input  logic     reqOth_i,
  output logic     valid_o,
  output port_id_e winner_o
);

  // Winner select: a lone requester always wins; on contention either the
  // pointer decides (round-robin) or ins wins (fixed priority).
  always_comb begin
    valid_o  = reqIns_i | reqOth_i;
    winner_o = PORT_INS;
`ifdef MEM_ARB_RR_EN
    if (reqIns_i && reqOth_i) begin
      winner_o = ptr_i;
    end else if (reqOth_i) begin
      winner_o = PORT_OTH;
    end
    // After each grant the loser gets next priority.
    ptrNext_o = (winner_o == PORT_INS) ? PORT_OTH : PORT_INS;
`else
    if (reqOth_i && !reqIns_i) begin
      winner_o = PORT_OTH;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_controller port between the instruction path
// (ins) and the other-data path (oth), one transaction at a time.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : mem_arbiter_if.slave carrying both requester ports, the
//              memory port and o_busy
// Parameters:
//   DATA_WIDTH : address/data width
//   RD_LAT     : cycles from the o_mem_ren cycle to valid i_mem_rdata (1..15)
// Macro MEM_ARB_RR_EN: defined builds the round-robin pointer; undefined
// gives fixed ins-first priority.
// Timing with the request seen in IDLE at cycle T: write -> o_mem_wen at T+1,
// ack at T+2; read -> o_mem_ren at T+1, ack and rdata at T+2+RD_LAT.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  state_e                state_q;
  port_id_e              win_q;
  op_e                   op_q;
  logic [CNT_W-1:0]      waitCnt_q;
  logic                  memRen_q;
  logic                  memWen_q;
  logic [DATA_WIDTH-1:0] memAddr_q;
  logic [DATA_WIDTH-1:0] memWdata_q;
  logic [DATA_WIDTH-1:0] insRdata_q;
  logic [DATA_WIDTH-1:0] othRdata_q;
  logic                  insAck_q;
  logic                  othAck_q;
  logic                  busy_q;

  logic                  pickValid;
  port_id_e              pickWinner;
  logic                  selWen;
  logic [DATA_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selWdata;

`ifdef MEM_ARB_RR_EN
  port_id_e              rrPtr_q;
  port_id_e              rrPtr_d;
`endif

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .ptr_i     (rrPtr_q),
    .ptrNext_o (rrPtr_d),
`endif
    .reqIns_i  (bus.i_ins_ren | bus.i_ins_wen),
    .reqOth_i  (bus.i_oth_ren | bus.i_oth_wen),
    .valid_o   (pickValid),
    .winner_o  (pickWinner)
  );

  // Route the winning port's request fields toward the latch registers.
  // wen takes precedence, so ren+wen together is handled as a write.
  always_comb begin
    selWen   = bus.i_ins_wen;
    selAddr  = bus.i_ins_addr;
    selWdata = bus.i_ins_wdata;
    if (pickWinner == PORT_OTH) begin
      selWen   = bus.i_oth_wen;
      selAddr  = bus.i_oth_addr;
      selWdata = bus.i_oth_wdata;
    end
  end

  // Transaction FSM. Every output is a register: the memory enables are set
  // on the IDLE->ISSUE edge so they are visible during ISSUE, and the ack is
  // set on the edge entering DONE. Enables and acks default low each cycle
  // so they are single-cycle pulses. Reset aborts any transaction silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= PORT_INS;
      op_q       <= OP_RD;
      waitCnt_q  <= '0;
      memRen_q   <= 1'b0;
      memWen_q   <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      insRdata_q <= '0;
      othRdata_q <= '0;
      insAck_q   <= 1'b0;
      othAck_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rrPtr_q    <= PORT_INS;
`endif
    end else begin
      memRen_q <= 1'b0;
      memWen_q <= 1'b0;
      insAck_q <= 1'b0;
      othAck_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            win_q      <= pickWinner;
            op_q       <= selWen ? OP_WR : OP_RD;
            memWen_q   <= selWen;
            memRen_q   <= ~selWen;
            memAddr_q  <= selAddr;
            memWdata_q <= selWdata;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
`ifdef MEM_ARB_RR_EN
            rrPtr_q    <= rrPtr_d;
`endif
          end
        end
        ISSUE: begin
          if (op_q == OP_WR) begin
            insAck_q <= (win_q == PORT_INS);
            othAck_q <= (win_q == PORT_OTH);
            state_q  <= DONE;
          end else begin
            waitCnt_q <= CNT_W'(RD_LAT - 1);
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          // Last WAIT cycle is exactly RD_LAT cycles after the ren cycle.
          if (waitCnt_q == '0) begin
            if (win_q == PORT_INS) begin
              insRdata_q <= bus.i_mem_rdata;
              insAck_q   <= 1'b1;
            end else begin
              othRdata_q <= bus.i_mem_rdata;
              othAck_q   <= 1'b1;
            end
            state_q <= DONE;
          end else begin
            waitCnt_q <= waitCnt_q - 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_mem_ren   = memRen_q;
  assign bus.o_mem_wen   = memWen_q;
  assign bus.o_mem_addr  = memAddr_q;
  assign bus.o_mem_wdata = memWdata_q;
  assign bus.o_ins_rdata = insRdata_q;
  assign bus.o_oth_rdata = othRdata_q;
  assign bus.o_ins_ack   = insAck_q;
  assign bus.o_oth_ack   = othAck_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (RD_LAT = 3).
// Inputs are driven 1 ns after each rising edge and outputs are checked at
// the same point, so every check sees the registered state of that cycle.
// Expectations for the contention test follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

  localparam int DW     = 32;
  localparam int RD_LAT = 3;

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] expInsRdata;
  logic [31:0] expOthRdata;
  int          insAcks;
  int          othAcks;
  int          n;
  logic        expInsWin;

  mem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  mem_arbiter #(
    .DATA_WIDTH (DW),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic insRen, input logic insWen,
                               input logic [31:0] insAddr, input logic [31:0] insWdata,
                               input logic othRen, input logic othWen,
                               input logic [31:0] othAddr, input logic [31:0] othWdata);
    bus.i_ins_ren   = insRen;
    bus.i_ins_wen   = insWen;
    bus.i_ins_addr  = insAddr;
    bus.i_ins_wdata = insWdata;
    bus.i_oth_ren   = othRen;
    bus.i_oth_wen   = othWen;
    bus.i_oth_addr  = othAddr;
    bus.i_oth_wdata = othWdata;
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, " busy"},      32'(bus.o_busy),    32'd0);
    checkOutput({pfx, " ins_ack"},   32'(bus.o_ins_ack), 32'd0);
    checkOutput({pfx, " oth_ack"},   32'(bus.o_oth_ack), 32'd0);
    checkOutput({pfx, " mem_ren"},   32'(bus.o_mem_ren), 32'd0);
    checkOutput({pfx, " mem_wen"},   32'(bus.o_mem_wen), 32'd0);
    checkOutput({pfx, " mem_addr"},  bus.o_mem_addr,     32'd0);
    checkOutput({pfx, " mem_wdata"}, bus.o_mem_wdata,    32'd0);
    checkOutput({pfx, " ins_rdata"}, bus.o_ins_rdata,    32'd0);
    checkOutput({pfx, " oth_rdata"}, bus.o_oth_rdata,    32'd0);
  endtask

  // One read from a single requester, starting in an IDLE cycle (cycle T).
  // Memory data is only valid in cycle T+1+RD_LAT; other cycles show junk.
  task automatic readTxn(input logic isOth, input logic [31:0] addr,
                         input logic [31:0] data);
    if (isOth) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, addr, 32'd0);
    else       applyStimulus(1'b1, 1'b0, addr, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    bus.i_mem_rdata = 32'hDEADBEEF;
    step;
    checkOutput("rd mem_ren",  32'(bus.o_mem_ren), 32'd1);
    checkOutput("rd mem_wen",  32'(bus.o_mem_wen), 32'd0);
    checkOutput("rd mem_addr", bus.o_mem_addr,     addr);
    checkOutput("rd busy",     32'(bus.o_busy),    32'd1);
    for (int i = 0; i < RD_LAT; i++) begin
      step;
      checkOutput("rd early ack", 32'(bus.o_ins_ack | bus.o_oth_ack), 32'd0);
      checkOutput("rd ren pulse", 32'(bus.o_mem_ren), 32'd0);
      if (i == RD_LAT - 1) bus.i_mem_rdata = data;
    end
    step;
    if (isOth) expOthRdata = data;
    else       expInsRdata = data;
    checkOutput("rd ins_ack",   32'(bus.o_ins_ack), 32'(!isOth));
    checkOutput("rd oth_ack",   32'(bus.o_oth_ack), 32'(isOth));
    checkOutput("rd ins_rdata", bus.o_ins_rdata,    expInsRdata);
    checkOutput("rd oth_rdata", bus.o_oth_rdata,    expOthRdata);
    bus.i_mem_rdata = 32'hDEADBEEF;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step;
    checkOutput("rd ack one cycle", 32'(bus.o_ins_ack | bus.o_oth_ack), 32'd0);
    checkOutput("rd back to idle",  32'(bus.o_busy), 32'd0);
    checkOutput("rd ins_rdata held", bus.o_ins_rdata, expInsRdata);
    checkOutput("rd oth_rdata held", bus.o_oth_rdata, expOthRdata);
  endtask

  initial begin
    // Reset: all outputs zero.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    bus.i_mem_rdata = 32'hDEADBEEF;
    step;
    step;
    checkAllZero("reset");
    rst = 1'b0;
    expInsRdata = 32'd0;
    expOthRdata = 32'd0;
    step;
    checkOutput("idle no request busy", 32'(bus.o_busy), 32'd0);

    // ins write: wen at T+1, ack at T+2.
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, 1'b0, 1'b0, 32'd0, 32'd0);
    step;
    checkOutput("wr mem_wen",    32'(bus.o_mem_wen), 32'd1);
    checkOutput("wr mem_ren",    32'(bus.o_mem_ren), 32'd0);
    checkOutput("wr mem_addr",   bus.o_mem_addr,     32'h10);
    checkOutput("wr mem_wdata",  bus.o_mem_wdata,    32'hA5A5A5A5);
    checkOutput("wr early ack",  32'(bus.o_ins_ack), 32'd0);
    step;
    checkOutput("wr ins_ack",    32'(bus.o_ins_ack), 32'd1);
    checkOutput("wr oth_ack",    32'(bus.o_oth_ack), 32'd0);
    checkOutput("wr wen pulse",  32'(bus.o_mem_wen), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step;
    checkOutput("wr ack one cycle", 32'(bus.o_ins_ack), 32'd0);
    checkOutput("wr back to idle",  32'(bus.o_busy),    32'd0);

    // Reads on each port; the other port's rdata must stay put.
    readTxn(1'b0, 32'h30, 32'h0BADF00D);
    readTxn(1'b1, 32'h20, 32'h12345678);

    // ins ren+wen together is a write.
    applyStimulus(1'b1, 1'b1, 32'h44, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0, 32'd0);
    step;
    checkOutput("rw mem_wen",   32'(bus.o_mem_wen), 32'd1);
    checkOutput("rw mem_ren",   32'(bus.o_mem_ren), 32'd0);
    checkOutput("rw mem_wdata", bus.o_mem_wdata,    32'hCAFEF00D);
    step;
    checkOutput("rw ins_ack",   32'(bus.o_ins_ack), 32'd1);
    checkOutput("rw ins_rdata", bus.o_ins_rdata,    expInsRdata);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step;

    // Reset during WAIT of an ins read, with oth waiting behind it.
    applyStimulus(1'b1, 1'b0, 32'h50, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step;
    checkOutput("abort mem_ren", 32'(bus.o_mem_ren), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h50, 32'd0, 1'b1, 1'b0, 32'h60, 32'd0);
    step;
    checkOutput("abort in wait busy", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h60, 32'd0);
    step;
    checkAllZero("abort");
    expInsRdata = 32'd0;
    expOthRdata = 32'd0;
    rst = 1'b0;
    readTxn(1'b1, 32'h60, 32'h77778888);

    // Both ports hold read requests; watch the grant sequence.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'd0, 1'b1, 1'b0, 32'h200, 32'd0);
    bus.i_mem_rdata = 32'h0000AAAA;
    insAcks = 0;
    othAcks = 0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin
        step;
        n++;
        if (bus.o_ins_ack) insAcks++;
        if (bus.o_oth_ack) othAcks++;
      end while (!(bus.o_ins_ack || bus.o_oth_ack) && n < 20);
      checkOutput("contend grant spacing", 32'(n), (g == 0) ? 32'(2 + RD_LAT) : 32'(3 + RD_LAT));
`ifdef MEM_ARB_RR_EN
      expInsWin = ((g % 2) == 0);
`else
      expInsWin = 1'b1;
`endif
      checkOutput("contend ins_ack", 32'(bus.o_ins_ack), 32'(expInsWin));
      checkOutput("contend oth_ack", 32'(bus.o_oth_ack), 32'(!expInsWin));
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step;
`ifdef MEM_ARB_RR_EN
    checkOutput("contend ins count", 32'(insAcks), 32'd2);
    checkOutput("contend oth count", 32'(othAcks), 32'd2);
`else
    checkOutput("contend ins count", 32'(insAcks), 32'd4);
    checkOutput("contend oth count", 32'(othAcks), 32'd0);
`endif
    checkOutput("contend idle busy", 32'(bus.o_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
